// File: rtl/score_display_scan.sv
// Binary score -> 3-digit BCD (sequential shift-add-3) with a multiplexed, leading-zero-blanked
// seven-segment scan. Optional post-commit blink is enabled by defining SCORE_FLASH_EN.
module score_display_scan #(
    parameter int SCAN_DIV     = 100000,
    parameter int FLASH_FRAMES = 8
) (
    input  logic        clk,
    input  logic        r_n,
    input  logic [7:0]  score,
    output logic [11:0] bcd,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg
);
    localparam int PW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t        state, state_nx;
    logic [7:0]    score_q, last, cval;
    logic [19:0]   sh;
    logic [11:0]   adj;
    logic [2:0]    step;
    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic          tick, frame_end, flash_blank;
    logic [3:0]    nib;
    logic [6:0]    pat, seg_nx;
    logic [3:0]    an_nx;
    logic          blank;

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (score_q != last) state_nx = CONV;
            CONV:    if (step == 3'd7)    state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Upper 12 bits of sh hold the BCD accumulator, lower 8 the binary being shifted in.
    always_comb begin
        adj = sh[19:8];
        for (int i = 0; i < 3; i++)
            if (sh[8+4*i +: 4] >= 4'd5) adj[4*i +: 4] = sh[8+4*i +: 4] + 4'd3;
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            score_q <= '0;
            last    <= '0;
            cval    <= '0;
            sh      <= '0;
            step    <= '0;
            bcd     <= '0;
        end else begin
            score_q <= score;
            case (state)
                IDLE: if (score_q != last) begin
                    sh   <= {12'h000, score_q};
                    cval <= score_q;
                    step <= '0;
                end
                CONV: begin
                    sh   <= {adj, sh[7:0]} << 1;
                    step <= step + 3'd1;
                end
                COMMIT: begin
                    bcd  <= sh[19:8];
                    last <= cval;
                end
                default: ;
            endcase
        end
    end

    assign tick      = (presc == PW'(SCAN_DIV - 1));
    assign frame_end = tick && (idx == 2'd3);

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

`ifdef SCORE_FLASH_EN
    logic [15:0] fcnt;

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n)                        fcnt <= '0;
        else if (state == COMMIT)        fcnt <= 16'(FLASH_FRAMES);
        else if (frame_end && fcnt != 0) fcnt <= fcnt - 16'd1;
    end

    assign flash_blank = fcnt[0];
`else
    logic unused_flash;
    assign unused_flash = frame_end;
    assign flash_blank  = 1'b0;
`endif

    always_comb begin
        case (idx)
            2'd0:    nib = bcd[3:0];
            2'd1:    nib = bcd[7:4];
            default: nib = bcd[11:8];
        endcase
    end

    always_comb begin
        case (nib)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
    end

    assign blank  = (idx == 2'd3) ||
                    (idx == 2'd2 && bcd[11:8] == 4'd0) ||
                    (idx == 2'd1 && bcd[11:4] == 8'd0) ||
                    flash_blank;
    assign an_nx  = blank ? 4'b1111 : ~(4'b0001 << idx);
    assign seg_nx = blank ? 7'h7F : pat;

    // Registered pins so reset forces the blank pattern regardless of scan state.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
        end else begin
            an  <= an_nx;
            seg <= seg_nx;
        end
    end
endmodule

// File: tb/tb_score_display_scan.sv
// Directed bench for score_display_scan: latency, conversion values, blanking, overlap, reset,
// and (when SCORE_FLASH_EN is defined) the post-commit blink sequence.
module tb_score_display_scan;
    logic        clk = 1'b0;
    logic        r_n;
    logic [7:0]  score;
    logic [11:0] bcd;
    logic        busy;
    logic [3:0]  an;
    logic [6:0]  seg;

    int errors = 0;
    int checks = 0;

    score_display_scan #(.SCAN_DIV(2), .FLASH_FRAMES(4)) dut (
        .clk(clk), .r_n(r_n), .score(score), .bcd(bcd), .busy(busy), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Watch the pins for n cycles and record what each digit slot shows.
    task automatic observe(input int n,
                           output logic [6:0] s0, output logic [6:0] s1, output logic [6:0] s2,
                           output logic v0, output logic v1, output logic v2, output int bad);
        s0 = 7'h7F; s1 = 7'h7F; s2 = 7'h7F;
        v0 = 1'b0;  v1 = 1'b0;  v2 = 1'b0;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            case (an)
                4'b1110: begin v0 = 1'b1; s0 = seg; end
                4'b1101: begin v1 = 1'b1; s1 = seg; end
                4'b1011: begin v2 = 1'b1; s2 = seg; end
                4'b1111: if (seg !== 7'h7F) bad++;
                default: bad++;
            endcase
        end
    endtask

    logic [6:0] s0, s1, s2;
    logic       v0, v1, v2;
    int         bad;
    logic       busy_seen;

    initial begin
        r_n   = 1'b0;
        score = 8'd0;
        step(3);
        `CHK("rst_an",   an,   4'b1111)
        `CHK("rst_seg",  seg,  7'h7F)
        `CHK("rst_bcd",  bcd,  12'h000)
        `CHK("rst_busy", busy, 1'b0)

        r_n = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step(1);
            if (busy) busy_seen = 1'b1;
        end
        `CHK("zero_busy_never", busy_seen, 1'b0)
        observe(16, s0, s1, s2, v0, v1, v2, bad);
        `CHK("zero_ones_lit", v0, 1'b1)
        `CHK("zero_ones_seg", s0, 7'b1000000)
        `CHK("zero_tens_blank", v1, 1'b0)
        `CHK("zero_hund_blank", v2, 1'b0)
        `CHK("zero_bad_slots", bad, 0)

        // 255: edge k samples, busy from k+1, bcd at k+10
        score = 8'd255;
        step(1);
        `CHK("255_busy_k", busy, 1'b0)
        step(1);
        `CHK("255_busy_k1", busy, 1'b1)
        step(8);
        `CHK("255_busy_k9", busy, 1'b1)
        `CHK("255_bcd_k9", bcd, 12'h000)
        step(1);
        `CHK("255_bcd_k10", bcd, 12'h255)
        `CHK("255_busy_k10", busy, 1'b0)
        step(48);
        observe(16, s0, s1, s2, v0, v1, v2, bad);
        `CHK("255_ones_seg", s0, 7'b0010010)
        `CHK("255_tens_seg", s1, 7'b0010010)
        `CHK("255_hund_seg", s2, 7'b0100100)
        `CHK("255_bad_slots", bad, 0)

        score = 8'd7;
        step(10);
        `CHK("7_bcd_k9", bcd, 12'h255)
        step(1);
        `CHK("7_bcd_k10", bcd, 12'h007)
        step(48);
        observe(16, s0, s1, s2, v0, v1, v2, bad);
        `CHK("7_tens_blank", v1, 1'b0)
        `CHK("7_hund_blank", v2, 1'b0)
        `CHK("7_ones_seg", s0, 7'b1111000)
        `CHK("7_bad_slots", bad, 0)

        // 12, then 200 arriving while the 12 conversion is in flight
        score = 8'd12;
        step(4);
        score = 8'd200;
        bad = 0;
        for (int c = 4; c <= 22; c++) begin
            step(1);
            if (bcd !== 12'h007 && bcd !== 12'h012 && bcd !== 12'h200) bad++;
            if (c == 9)  `CHK("ovl_bcd_k9",  bcd, 12'h007)
            if (c == 10) `CHK("ovl_bcd_k10", bcd, 12'h012)
            if (c == 19) `CHK("ovl_bcd_k19", bcd, 12'h012)
            if (c == 20) `CHK("ovl_bcd_k20", bcd, 12'h200)
        end
        `CHK("ovl_no_stray_bcd", bad, 0)

        // Reset during CONV step 4
        score = 8'd99;
        step(6);
        `CHK("mid_busy_pre", busy, 1'b1)
        r_n = 1'b0;
        #1;
        `CHK("mid_rst_bcd",  bcd,  12'h000)
        `CHK("mid_rst_busy", busy, 1'b0)
        `CHK("mid_rst_an",   an,   4'b1111)
        step(2);
        r_n = 1'b1;
        step(10);
        `CHK("mid_bcd_j9",  bcd,  12'h000)
        `CHK("mid_busy_j9", busy, 1'b1)
        step(1);
        `CHK("mid_bcd_j10", bcd,  12'h099)

`ifdef SCORE_FLASH_EN
        begin
            logic [3:0] prev;
            logic       found;
            int         run, maxrun, longruns, ones;
            found = 1'b0;
            prev  = an;
            for (int i = 0; i < 64 && !found; i++) begin
                step(1);
                if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
                prev = an;
            end
            `CHK("fl_sync_found", found, 1'b1)
            // Place the commit exactly on a frame boundary.
            step(4);
            score = 8'd5;
            step(11);
            `CHK("fl_bcd", bcd, 12'h005)
            run = 0; maxrun = 0; longruns = 0; ones = 0;
            for (int i = 0; i < 64; i++) begin
                step(1);
                if (an == 4'b1110) ones++;
                if (an == 4'b1111) begin
                    run++;
                end else begin
                    if (run >= 13) longruns++;
                    if (run > maxrun) maxrun = run;
                    run = 0;
                end
            end
            if (run >= 13) longruns++;
            if (run > maxrun) maxrun = run;
            `CHK("fl_blank_frames", longruns, 2)
            `CHK("fl_max_gap", maxrun, 14)
            `CHK("fl_ones_lit", ones, 12)
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
